// File: rtl/divider_arbiter_pkg.sv
// divider_arbiter_pkg
//   Shared definitions for the divider arbiter: the controller state
//   encoding and the default parameter values used by the top level.
package divider_arbiter_pkg;

  // Controller states: wait for a request, pulse the divider start,
  // then wait for the divider to finish or time out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int NUM_REQ_DEFAULT        = 2;
  localparam int TIMEOUT_CYCLES_DEFAULT = 63;

endpackage : divider_arbiter_pkg

// File: rtl/divider_arbiter_rr_picker.sv
// rr_picker
//   Round-robin selector. Scans the eligible mask starting at rr_ptr and
//   wrapping around, and returns the first eligible index as a one-hot grant.
//   Ports:
//     eligible  [N-1:0]  requesters that may be granted this cycle
//     rr_ptr    [PW-1:0] index with highest priority (must be < N)
//     grant     [N-1:0]  one-hot grant, all-zero when nothing is eligible
//     any_grant          high when grant is non-zero
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  // One extra bit so rr_ptr + offset (< 2N) never overflows before wrapping.
  logic [PW:0] idx_s;

  // Priority scan from rr_ptr upward, wrapping once past N-1.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, rr_ptr} + (PW + 1)'(k);
      if (idx_s >= (PW + 1)'(N)) begin
        idx_s = idx_s - (PW + 1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!any_grant && eligible[idx_s[PW-1:0]]) begin
        grant[idx_s[PW-1:0]] = 1'b1;
        any_grant            = 1'b1;
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule : rr_picker

// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one external divider between NUM_REQ requesters. A requester is
//   eligible when it asserts req_valid and has no unconsumed result. The
//   controller grants one eligible requester (round-robin), latches its
//   operands, pulses div_start, then waits for the divider. The result (or a
//   timeout abort after TIMEOUT_CYCLES+1 wait cycles) is parked in the
//   owner's response slot until that requester consumes it.
//   Ports:
//     clk, reset_n                        clock, async active-low reset
//     req_valid/req_ready                 per-requester request handshake
//     req_dividend/divisor/is_8_bit/is_signed  per-requester operands
//     resp_valid/resp_ready               per-requester result handshake
//     resp_quotient/remainder/error/timeout    per-requester result slot
//     div_start/dividend/divisor/is_8_bit/is_signed  divider command
//     div_busy/complete/error/quotient/remainder     divider status/result
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_dividend,
  input  logic [NUM_REQ-1:0][15:0] req_divisor,
  input  logic [NUM_REQ-1:0]       req_is_8_bit,
  input  logic [NUM_REQ-1:0]       req_is_signed,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [NUM_REQ-1:0][15:0] resp_quotient,
  output logic [NUM_REQ-1:0][15:0] resp_remainder,
  output logic [NUM_REQ-1:0]       resp_error,
  output logic [NUM_REQ-1:0]       resp_timeout,
  output logic                     div_start,
  output logic                     div_is_8_bit,
  output logic                     div_is_signed,
  output logic [31:0]              div_dividend,
  output logic [15:0]              div_divisor,
  input  logic                     div_busy,
  input  logic                     div_complete,
  input  logic                     div_error,
  input  logic [15:0]              div_quotient,
  input  logic [15:0]              div_remainder
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                     state_r;
  state_e                     state_nxt_s;
  logic [PW-1:0]              rr_ptr_r;
  logic [PW-1:0]              owner_r;
  logic [CW-1:0]              cnt_r;
  logic [31:0]                dividend_r;
  logic [15:0]                divisor_r;
  logic                       is_8_bit_r;
  logic                       is_signed_r;
  logic                       div_start_r;
  logic [NUM_REQ-1:0]         resp_valid_r;
  logic [NUM_REQ-1:0]         resp_error_r;
  logic [NUM_REQ-1:0]         resp_timeout_r;
  logic [NUM_REQ-1:0][15:0]   resp_quotient_r;
  logic [NUM_REQ-1:0][15:0]   resp_remainder_r;

  logic [NUM_REQ-1:0]         eligible_s;
  logic [NUM_REQ-1:0]         grant_s;
  logic                       any_grant_s;
  logic [PW-1:0]              grant_idx_s;
  logic [PW-1:0]              next_ptr_s;
  logic                       accept_s;
  logic                       done_s;
  logic                       timeout_s;

  // Busy is informational only; completion is signalled by div_complete/div_error.
  logic                       unused_div_busy_s;
  assign unused_div_busy_s = div_busy;

  // Eligibility uses the registered response flag, so a slot being consumed
  // this cycle only becomes grantable on the following cycle.
  assign eligible_s = req_valid & ~resp_valid_r;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_picker (
    .eligible  (eligible_s),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .any_grant (any_grant_s)
  );

  // Encode the one-hot grant into an index (grant is one-hot, so OR is safe).
  always_comb begin
    grant_idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_idx_s = grant_idx_s | (grant_s[k] ? PW'(k) : PW'(0));
    end
  end

  // Round-robin pointer moves to the requester after the one just served.
  always_comb begin
    if (owner_r == PW'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_grant_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_s || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode. Divider completion wins over a same-cycle timeout,
  // and divider status outside WAIT is ignored.
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = grant_s;
        accept_s  = any_grant_s;
      end
      ST_START: begin
        req_ready = '0;
      end
      ST_WAIT: begin
        done_s    = div_complete | div_error;
        timeout_s = !(div_complete | div_error) && (cnt_r == CW'(TIMEOUT_CYCLES));
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

  // Latch the granted requester's operands and identity on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r     <= '0;
      dividend_r  <= 32'h0;
      divisor_r   <= 16'h0;
      is_8_bit_r  <= 1'b0;
      is_signed_r <= 1'b0;
    end else if (accept_s) begin
      owner_r     <= grant_idx_s;
      dividend_r  <= req_dividend[grant_idx_s];
      divisor_r   <= req_divisor[grant_idx_s];
      is_8_bit_r  <= req_is_8_bit[grant_idx_s];
      is_signed_r <= req_is_signed[grant_idx_s];
    end
  end

  // div_start is registered so it is high for exactly the START cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_start_r <= 1'b0;
    end else begin
      div_start_r <= accept_s;
    end
  end

  // Wait-cycle counter: cleared in START, counts every WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      case (state_r)
        ST_START: cnt_r <= '0;
        ST_WAIT:  cnt_r <= cnt_r + CW'(1);
        default:  cnt_r <= cnt_r;
      endcase
    end
  end

  // Round-robin pointer advances once per finished operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (done_s || timeout_s) begin
      rr_ptr_r <= next_ptr_s;
    end
  end

  // Response slots: consume on resp_ready, fill on completion or timeout.
  // The owner's slot is empty while its operation runs, so fill and
  // consume never target the same slot in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r     <= '0;
      resp_error_r     <= '0;
      resp_timeout_r   <= '0;
      resp_quotient_r  <= '0;
      resp_remainder_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid_r[i] && resp_ready[i]) begin
          resp_valid_r[i] <= 1'b0;
        end
      end
      if (done_s) begin
        resp_valid_r[owner_r]     <= 1'b1;
        resp_quotient_r[owner_r]  <= div_quotient;
        resp_remainder_r[owner_r] <= div_remainder;
        resp_error_r[owner_r]     <= div_error;
        resp_timeout_r[owner_r]   <= 1'b0;
      end else if (timeout_s) begin
        resp_valid_r[owner_r]     <= 1'b1;
        resp_quotient_r[owner_r]  <= 16'h0;
        resp_remainder_r[owner_r] <= 16'h0;
        resp_error_r[owner_r]     <= 1'b1;
        resp_timeout_r[owner_r]   <= 1'b1;
      end
    end
  end

  assign div_start      = div_start_r;
  assign div_dividend   = dividend_r;
  assign div_divisor    = divisor_r;
  assign div_is_8_bit   = is_8_bit_r;
  assign div_is_signed  = is_signed_r;
  assign resp_valid     = resp_valid_r;
  assign resp_error     = resp_error_r;
  assign resp_timeout   = resp_timeout_r;
  assign resp_quotient  = resp_quotient_r;
  assign resp_remainder = resp_remainder_r;

endmodule : divider_arbiter

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter
//   Directed bench for divider_arbiter with a behavioural divider stub
//   (fixed latency, optional hang). Inputs change 2 time units after the
//   rising edge; outputs are sampled on the falling edge.
module tb_divider_arbiter;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready, req_is_8_bit, req_is_signed;
  logic [1:0][31:0] req_dividend;
  logic [1:0][15:0] req_divisor;
  logic [1:0]       resp_valid, resp_ready, resp_error, resp_timeout;
  logic [1:0][15:0] resp_quotient, resp_remainder;
  logic             div_start, div_is_8_bit, div_is_signed;
  logic [31:0]      div_dividend;
  logic [15:0]      div_divisor;
  logic             div_busy, div_complete, div_error;
  logic [15:0]      div_quotient, div_remainder;

  int cmp_cnt = 0;
  int err_cnt = 0;

  divider_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_is_8_bit(req_is_8_bit), .req_is_signed(req_is_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_error(resp_error), .resp_timeout(resp_timeout),
    .div_start(div_start), .div_is_8_bit(div_is_8_bit), .div_is_signed(div_is_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_complete(div_complete), .div_error(div_error),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- divider stub ----------------
  logic        stub_hang, spur_complete;
  logic        stub_busy_r, stub_done_r, stub_err_r, stub_pend_err_r;
  logic [3:0]  stub_cnt_r;
  logic [15:0] stub_q_r, stub_r_r;
  logic [32:0] stub_res_s;

  function automatic logic [32:0] stub_div(input logic [31:0] dd, input logic [15:0] dv,
                                           input logic is8, input logic sgn);
    longint a, b, q, r, lo, hi;
    if (is8) begin
      a  = sgn ? longint'($signed(dd[15:0])) : longint'(dd[15:0]);
      b  = sgn ? longint'($signed(dv[7:0]))  : longint'(dv[7:0]);
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
    end else begin
      a  = sgn ? longint'($signed(dd)) : longint'(dd);
      b  = sgn ? longint'($signed(dv)) : longint'(dv);
      lo = sgn ? -32768 : 0;
      hi = sgn ? 32767 : 65535;
    end
    if (b == 0) return {1'b1, 32'h0};
    q = a / b;
    r = a % b;
    if (q < lo || q > hi) return {1'b1, 32'h0};
    return {1'b0, q[15:0], r[15:0]};
  endfunction

  assign stub_res_s = stub_div(div_dividend, div_divisor, div_is_8_bit, div_is_signed);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_busy_r <= 1'b0; stub_done_r <= 1'b0; stub_err_r <= 1'b0; stub_pend_err_r <= 1'b0;
      stub_cnt_r <= 4'd0; stub_q_r <= 16'h0; stub_r_r <= 16'h0;
    end else begin
      stub_done_r <= 1'b0;
      stub_err_r  <= 1'b0;
      if (div_start && !stub_hang) begin
        stub_busy_r     <= 1'b1;
        stub_cnt_r      <= 4'd2;
        stub_pend_err_r <= stub_res_s[32];
        stub_q_r        <= stub_res_s[31:16];
        stub_r_r        <= stub_res_s[15:0];
      end else if (stub_busy_r) begin
        if (stub_cnt_r == 4'd0) begin
          stub_busy_r <= 1'b0;
          if (stub_pend_err_r) stub_err_r <= 1'b1;
          else stub_done_r <= 1'b1;
        end else begin
          stub_cnt_r <= stub_cnt_r - 4'd1;
        end
      end
    end
  end

  assign div_busy      = stub_busy_r;
  assign div_complete  = stub_done_r | spur_complete;
  assign div_error     = stub_err_r;
  assign div_quotient  = stub_q_r;
  assign div_remainder = stub_r_r;

  // ---------------- monitors ----------------
  int          start_cnt = 0;
  int          acc_q[$];
  logic [34:0] rsp_q[$];

  always @(negedge clk) begin
    if (reset_n && div_start) start_cnt <= start_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset_n && req_valid[i] && req_ready[i]) acc_q.push_back(i);
      if (reset_n && resp_valid[i] && resp_ready[i])
        rsp_q.push_back({i[0], resp_quotient[i], resp_remainder[i], resp_error[i], resp_timeout[i]});
    end
  end

  // ---------------- helpers ----------------
  task automatic drive_pt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 2'b00; req_is_8_bit = 2'b00; req_is_signed = 2'b00;
    req_dividend = '0; req_divisor = '0; resp_ready = 2'b00;
    stub_hang = 1'b0; spur_complete = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] dd, input logic [15:0] dv,
                         input logic is8, input logic sgn);
    req_dividend[i] = dd; req_divisor[i] = dv;
    req_is_8_bit[i] = is8; req_is_signed[i] = sgn; req_valid[i] = 1'b1;
  endtask

  task automatic wait_resp(input int i, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (resp_valid[i]) begin ok = 1'b1; break; end
    end
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL wait_resp%0d: resp_valid not seen in %0d cycles", i, budget); end
  endtask

  task automatic wait_ready(input int i, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL wait_ready%0d: req_ready not seen in %0d cycles", i, budget); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 2'b00; resp_ready = 2'b00; stub_hang = 1'b0; spur_complete = 1'b0;
    req_dividend = '0; req_divisor = '0; req_is_8_bit = 2'b00; req_is_signed = 2'b00;
    #1;
    cmp_cnt++;
    if ({resp_valid, resp_error, resp_timeout} !== 6'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b required 000000", {resp_valid, resp_error, resp_timeout});
    end
    cmp_cnt++;
    if ({div_start, div_dividend, div_divisor} !== 49'b0) begin
      err_cnt++; $display("FAIL reset_div: got start=%b dd=%h dv=%h required 0", div_start, div_dividend, div_divisor);
    end
    cmp_cnt++;
    if ({resp_quotient, resp_remainder} !== 64'b0) begin
      err_cnt++; $display("FAIL reset_data: got %h required 0", {resp_quotient, resp_remainder});
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({req_ready, div_start} !== 3'b0) begin
      err_cnt++; $display("FAIL reset_idle: got ready=%b start=%b required 0", req_ready, div_start);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    spur_complete = 1'b1;
    drive_pt();
    spur_complete = 1'b0;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (resp_valid !== 2'b00) begin
      err_cnt++; $display("FAIL spurious_complete: got resp_valid=%b required 00", resp_valid);
    end
  endtask

  task automatic test_basic();
    int s0;
    do_reset();
    s0 = start_cnt;
    set_req(0, 32'd100, 16'd5, 1'b1, 1'b0);
    @(negedge clk);
    cmp_cnt++;
    if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL basic_ready: got %b required 01", req_ready); end
    drive_pt();
    @(negedge clk);
    cmp_cnt++;
    if ({div_start, div_dividend, div_divisor, div_is_8_bit, div_is_signed} !== {1'b1, 32'd100, 16'd5, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL basic_start: got start=%b dd=%0d dv=%0d m8=%b sg=%b required 1 100 5 1 0",
                          div_start, div_dividend, div_divisor, div_is_8_bit, div_is_signed);
    end
    cmp_cnt++;
    if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL basic_ready_start: got %b required 00", req_ready); end
    drive_pt();
    req_valid[0] = 1'b0;
    wait_resp(0, 50);
    cmp_cnt++;
    if ({resp_quotient[0], resp_remainder[0], resp_error[0], resp_timeout[0]} !== {16'd20, 16'd0, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL basic_result: got q=%0d r=%0d e=%b t=%b required 20 0 0 0",
                          resp_quotient[0], resp_remainder[0], resp_error[0], resp_timeout[0]);
    end
    cmp_cnt++;
    if ({div_dividend, div_divisor} !== {32'd100, 16'd5}) begin
      err_cnt++; $display("FAIL basic_operands_hold: got dd=%0d dv=%0d required 100 5", div_dividend, div_divisor);
    end
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({resp_valid[0], resp_quotient[0]} !== {1'b1, 16'd20}) begin
      err_cnt++; $display("FAIL basic_hold: got v=%b q=%0d required 1 20", resp_valid[0], resp_quotient[0]);
    end
    drive_pt();
    cmp_cnt++;
    if (start_cnt - s0 !== 1) begin err_cnt++; $display("FAIL basic_start_pulses: got %0d required 1", start_cnt - s0); end
    resp_ready[0] = 1'b1;
    drive_pt();
    resp_ready[0] = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (resp_valid !== 2'b00) begin err_cnt++; $display("FAIL basic_consume: got %b required 00", resp_valid); end
  endtask

  task automatic test_contention();
    int base_a, base_r;
    bit ok = 1'b0;
    logic [34:0] exp_rsp [4];
    exp_rsp[0] = {1'b0, 16'd123, 16'd45, 1'b0, 1'b0};
    exp_rsp[1] = {1'b1, 16'hFF9C, 16'd0, 1'b0, 1'b0};
    exp_rsp[2] = {1'b0, 16'd123, 16'd45, 1'b0, 1'b0};
    exp_rsp[3] = {1'b1, 16'hFF9C, 16'd0, 1'b0, 1'b0};
    do_reset();
    base_a = acc_q.size();
    base_r = rsp_q.size();
    resp_ready = 2'b11;
    set_req(0, 32'd12345, 16'd100, 1'b0, 1'b0);
    set_req(1, 32'hFFFF_FC18, 16'd10, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rsp_q.size() >= base_r + 4) begin ok = 1'b1; break; end
    end
    drive_pt();
    req_valid = 2'b00;
    resp_ready = 2'b00;
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL contention_wait: got %0d responses required 4", rsp_q.size() - base_r); end
    for (int k = 0; k < 4; k++) begin
      cmp_cnt++;
      if (acc_q.size() <= base_a + k) begin
        err_cnt++; $display("FAIL contention_grant%0d: got no accept required req%0d", k, k % 2);
      end else if (acc_q[base_a + k] !== k % 2) begin
        err_cnt++; $display("FAIL contention_grant%0d: got req%0d required req%0d", k, acc_q[base_a + k], k % 2);
      end
      cmp_cnt++;
      if (rsp_q.size() <= base_r + k) begin
        err_cnt++; $display("FAIL contention_resp%0d: got none required %h", k, exp_rsp[k]);
      end else if (rsp_q[base_r + k] !== exp_rsp[k]) begin
        err_cnt++; $display("FAIL contention_resp%0d: got %h required %h", k, rsp_q[base_r + k], exp_rsp[k]);
      end
    end
  endtask

  task automatic test_div_error();
    do_reset();
    set_req(1, 32'd100, 16'd0, 1'b0, 1'b0);
    wait_ready(1, 5);
    drive_pt();
    req_valid[1] = 1'b0;
    wait_resp(1, 50);
    cmp_cnt++;
    if ({resp_error[1], resp_timeout[1], resp_valid[0]} !== 3'b100) begin
      err_cnt++; $display("FAIL div_error: got e=%b t=%b v0=%b required 1 0 0", resp_error[1], resp_timeout[1], resp_valid[0]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok = 1'b0;
    do_reset();
    stub_hang = 1'b1;
    set_req(0, 32'd100, 16'd5, 1'b1, 1'b0);
    set_req(1, 32'd12345, 16'd100, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (div_start) begin ok = 1'b1; break; end
    end
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL timeout_start: got no div_start required pulse"); end
    drive_pt();
    req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (resp_valid[0]) begin ok = 1'b1; break; end
    end
    // n counts the WAIT entry cycle as 1; the response lands 64 cycles later.
    cmp_cnt++;
    if (!ok || n !== 65) begin err_cnt++; $display("FAIL timeout_latency: got %0d (seen=%b) required 65", n, ok); end
    cmp_cnt++;
    if ({resp_error[0], resp_timeout[0], resp_quotient[0], resp_remainder[0]} !== {1'b1, 1'b1, 32'h0}) begin
      err_cnt++; $display("FAIL timeout_result: got e=%b t=%b q=%h r=%h required 1 1 0 0",
                          resp_error[0], resp_timeout[0], resp_quotient[0], resp_remainder[0]);
    end
    cmp_cnt++;
    if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL timeout_idle: got ready=%b required 10", req_ready); end
  endtask

  task automatic test_backpressure();
    logic [1:0] seen;
    do_reset();
    set_req(0, 32'd100, 16'd5, 1'b1, 1'b0);
    wait_resp(0, 50);
    seen = 2'b00;
    repeat (3) begin @(negedge clk); seen = seen | req_ready; end
    cmp_cnt++;
    if (seen !== 2'b00) begin err_cnt++; $display("FAIL bp_blocked: got ready=%b required 00", seen); end
    drive_pt();
    set_req(1, 32'd12345, 16'd100, 1'b0, 1'b0);
    wait_ready(1, 5);
    cmp_cnt++;
    if (req_ready !== 2'b10) begin err_cnt++; $display("FAIL bp_req1_grant: got %b required 10", req_ready); end
    drive_pt();
    req_valid[1] = 1'b0;
    wait_resp(1, 50);
    cmp_cnt++;
    if ({resp_quotient[1], resp_remainder[1]} !== {16'd123, 16'd45}) begin
      err_cnt++; $display("FAIL bp_req1_result: got q=%0d r=%0d required 123 45", resp_quotient[1], resp_remainder[1]);
    end
    drive_pt();
    resp_ready[1] = 1'b1;
    drive_pt();
    resp_ready[1] = 1'b0;
    seen = 2'b00;
    repeat (3) begin @(negedge clk); seen = seen | req_ready; end
    cmp_cnt++;
    if (seen !== 2'b00) begin err_cnt++; $display("FAIL bp_still_blocked: got ready=%b required 00", seen); end
    drive_pt();
    resp_ready[0] = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL bp_same_cycle: got ready=%b required 00", req_ready); end
    drive_pt();
    resp_ready[0] = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if ({req_ready, resp_valid[0]} !== 3'b010) begin
      err_cnt++; $display("FAIL bp_next_cycle: got ready=%b v0=%b required 01 0", req_ready, resp_valid[0]);
    end
  endtask

  task automatic test_reset_in_wait();
    int hits = 0;
    bit ok = 1'b0;
    do_reset();
    stub_hang = 1'b1;
    set_req(0, 32'd100, 16'd5, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (div_start) begin ok = 1'b1; break; end
    end
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL rst_wait_start: got no div_start required pulse"); end
    drive_pt();
    req_valid[0] = 1'b0;
    repeat (3) drive_pt();
    reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({div_start, div_dividend, div_divisor, div_is_8_bit} !== 50'b0) begin
      err_cnt++; $display("FAIL rst_wait_div: got start=%b dd=%h dv=%h m8=%b required 0",
                          div_start, div_dividend, div_divisor, div_is_8_bit);
    end
    cmp_cnt++;
    if ({resp_valid, resp_error, resp_timeout, req_ready} !== 8'b0) begin
      err_cnt++; $display("FAIL rst_wait_flags: got %b required 0", {resp_valid, resp_error, resp_timeout, req_ready});
    end
    stub_hang = 1'b0;
    drive_pt();
    reset_n = 1'b1;
    repeat (80) begin @(negedge clk); if (resp_valid !== 2'b00 || div_start) hits++; end
    cmp_cnt++;
    if (hits !== 0) begin err_cnt++; $display("FAIL rst_wait_no_resp: got %0d active cycles required 0", hits); end
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_basic();
    test_contention();
    test_div_error();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_divider_arbiter

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one Divider.
REQ-002 Parameter TIMEOUT_CYCLES, default 63: maximum WAIT cycles before the operation is aborted.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; a request is taken when req_valid and req_ready are both high.
REQ-007 req_dividend/req_divisor  input  NUM_REQ x 32 / NUM_REQ x 16  per-requester operands.
REQ-008 req_is_8_bit/req_is_signed  input  NUM_REQ each  per-requester mode bits.
REQ-009 resp_valid  output  NUM_REQ  per-requester result pending.
REQ-010 resp_ready  input  NUM_REQ  per-requester result consume.
REQ-011 resp_quotient/resp_remainder  output  NUM_REQ x 16 each  captured result.
REQ-012 resp_error/resp_timeout  output  NUM_REQ each  divide error (zero or overflow); timeout abort.
REQ-013 div_start, div_is_8_bit, div_is_signed (1 each), div_dividend (32), div_divisor (16)  output  drive the Divider.
REQ-014 div_busy, div_complete, div_error (1 each), div_quotient, div_remainder (16 each)  input  Divider status and results.

Function
REQ-015 The FSM SHALL have states IDLE, START and WAIT.
REQ-016 IDLE: eligible(i) = req_valid[i] and not resp_valid[i]. Grant the first eligible index at or after rr_ptr, wrapping. Assert req_ready only for that index, combinationally. Latch its operands, owner index and mode bits. Go to START.
REQ-017 req_ready SHALL be low for every requester outside IDLE and for non-granted requesters.
REQ-018 START: div_start high for exactly one cycle. Clear the timeout counter. Go to WAIT.
REQ-019 div_dividend, div_divisor, div_is_8_bit and div_is_signed SHALL be driven from the latched registers, stable from START through WAIT.
REQ-020 WAIT: the counter increments each cycle.
- On div_complete or div_error: capture div_quotient, div_remainder and resp_error=div_error into owner slots; resp_timeout=0.
- Else, on counter==TIMEOUT_CYCLES: set resp_error=1, resp_timeout=1, quotient and remainder 0.
- Either event: set resp_valid[owner], set rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
REQ-021 Priority: div_complete or div_error in the same cycle as timeout SHALL win, with resp_timeout=0.
REQ-022 resp_valid[i] SHALL hold, with stable data, until a cycle where resp_ready[i] is high; it clears on the next edge.
REQ-023 Grant eligibility uses registered resp_valid. A requester consuming its result can therefore be granted one cycle later, not in the same cycle.
REQ-024 div_complete or div_error seen outside WAIT SHALL be ignored.
REQ-025 Minimum latency, request accept to resp_valid: Divider latency + 2 cycles.

Reset
REQ-026 While reset_n is low, asynchronously: state=IDLE, rr_ptr=0, counter=0, all resp_valid/resp_error/resp_timeout=0, resp data=0, div_start=0, latched operands=0.
REQ-027 Reset mid-WAIT SHALL discard the operation with no response. The bench resets the Divider together with this block.

Structure
REQ-028 Package divider_arbiter_pkg SHALL hold the state enum and the TIMEOUT_CYCLES default constant.
REQ-029 Round-robin selection SHALL be a sub-module rr_picker: inputs eligible mask and rr_ptr; outputs one-hot grant and any_grant.
REQ-030 The Divider is instantiated outside this block.

Verification
REQ-031 req0 sends 100/5, 8-bit, unsigned -> one div_start pulse; resp_valid[0] with Q=20, R=0, error=0, timeout=0.
REQ-032 req0 and req1 assert together after reset (req0 12345/100 16-bit, req1 -1000/10 16-bit signed) -> req0 served first (Q=123, R=45), then req1 (Q=0xFF9C); rr_ptr alternates over repeated contention.
REQ-033 req1 sends 100/0 -> resp_error[1]=1, resp_timeout[1]=0.
REQ-034 Stub Divider that never completes -> resp_error=1 and resp_timeout=1 exactly 64 cycles after the WAIT entry cycle (counter 0 through 63); FSM returns to IDLE.
REQ-035 resp_ready[0] held low while req0 re-requests -> req0 not granted and req1 served; after resp_ready[0] pulses, req0 is granted one cycle later.
REQ-036 reset_n driven low during WAIT -> all outputs reach reset values immediately; no resp_valid after release.
